bus_coherence_ctrl: RTL and testbench

BUS_COHERENCE_CTRL -- requirements
Module: bus_coherence_ctrl

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/coherence_rr_arb.sv | 21 ++
 rtl/bus_coherence_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bus_coherence_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, bus word and the
// coherence controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SNOOP  = 4'd1,
    SWB1   = 4'd2,
    SWB2   = 4'd3,
    DREAD1 = 4'd4,
    DREAD2 = 4'd5,
    DWB1   = 4'd6,
    DWB2   = 4'd7,
    IFETCH = 4'd8
  } coh_state_t;

endpackage

// File: rtl/coherence_rr_arb.sv
// Two-way round-robin pick: on a tie the pointed core wins, otherwise
// the single requester wins. Purely combinational.
module coherence_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       valid
);

  // Resolve the request vector and pointer into a grant index
  always_comb begin
    valid = |req;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ptr;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_coherence_ctrl.sv
// Two-core snooping bus controller in front of a single-port RAM.
// Data requests beat instruction fetches; a data read first snoops the
// other core and, if that core holds a dirty copy, writes it back before
// the two-word read. Outputs decode from the state register so the RAM
// request is up in the very cycle a state is entered.
module bus_coherence_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             iREN,
  input  logic [1:0][WORD_W-1:0] iaddr,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  input  logic [1:0]             ccwrite,
  output logic [1:0]             iwait,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] iload,
  output logic [1:0][WORD_W-1:0] dload,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  coh_state_t state_r;
  logic       core_r;
  logic       dptr_r;
  logic       iptr_r;
  logic       inv_r;

  logic [1:0] d_req_s;
  logic       d_grant_s;
  logic       d_valid_s;
  logic       i_grant_s;
  logic       i_valid_s;
  logic       other_s;
  logic       access_s;

  assign d_req_s  = dREN | dWEN;
  assign other_s  = ~core_r;
  assign access_s = (ramstate_t'(ramstate) == ACCESS);

  coherence_rr_arb u_data_arb (
    .req   (d_req_s),
    .ptr   (dptr_r),
    .grant (d_grant_s),
    .valid (d_valid_s)
  );

  coherence_rr_arb u_inst_arb (
    .req   (iREN),
    .ptr   (iptr_r),
    .grant (i_grant_s),
    .valid (i_valid_s)
  );

  // Transaction sequencing; FREE/BUSY/ERROR simply hold the current state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      core_r  <= 1'b0;
      dptr_r  <= 1'b0;
      iptr_r  <= 1'b0;
      inv_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (d_valid_s) begin
            core_r  <= d_grant_s;
            state_r <= dWEN[d_grant_s] ? DWB1 : SNOOP;
          end else if (i_valid_s) begin
            core_r  <= i_grant_s;
            state_r <= IFETCH;
          end
        end
        SNOOP: begin
          // Invalidate intent is latched so it holds through the writeback
          inv_r   <= ccwrite[core_r];
          state_r <= ccwrite[other_s] ? SWB1 : DREAD1;
        end
        SWB1:   if (access_s) state_r <= SWB2;
        SWB2:   if (access_s) state_r <= DREAD1;
        DREAD1: if (access_s) state_r <= DREAD2;
        DREAD2: begin
          if (access_s) begin
            state_r <= IDLE;
            dptr_r  <= other_s;
          end
        end
        DWB1:   if (access_s) state_r <= DWB2;
        DWB2:   if (access_s) state_r <= IDLE;
        IFETCH: begin
          if (access_s) begin
            state_r <= IDLE;
            iptr_r  <= other_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Bus, snoop and stall decode from the current state and RAM handshake
  always_comb begin
    dwait       = 2'b11;
    iwait       = 2'b11;
    dload       = '0;
    iload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_r)
      IDLE: begin
        ramREN = 1'b0;
      end
      SNOOP: begin
        ccwait[other_s]      = 1'b1;
        ccsnoopaddr[other_s] = daddr[core_r];
        ccinv[other_s]       = ccwrite[core_r];
      end
      SWB1, SWB2: begin
        ccwait[other_s] = 1'b1;
        ccinv[other_s]  = inv_r;
        ramWEN          = 1'b1;
        ramaddr         = daddr[other_s];
        ramstore        = dstore[other_s];
      end
      DREAD1, DREAD2: begin
        ramREN        = 1'b1;
        ramaddr       = daddr[core_r];
        dload[core_r] = ramload;
        dwait[core_r] = ~access_s;
      end
      DWB1, DWB2: begin
        ramWEN        = 1'b1;
        ramaddr       = daddr[core_r];
        ramstore      = dstore[core_r];
        dwait[core_r] = ~access_s;
      end
      IFETCH: begin
        ramREN        = 1'b1;
        ramaddr       = iaddr[core_r];
        iload[core_r] = ramload;
        iwait[core_r] = ~access_s;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// Directed bench for bus_coherence_ctrl: snooped reads, dirty writeback,
// arbitration order, writes, RAM ERROR hold and mid-transaction reset.
module tb_bus_coherence_ctrl;

  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       ccwrite;
  logic [1:0]       iwait;
  logic [1:0]       dwait;
  logic [1:0][31:0] iload;
  logic [1:0][31:0] dload;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;

  int checks;
  int errors;

  bus_coherence_ctrl #(.WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00; ccwrite = 2'b00;
    iaddr = '0; daddr = '0; dstore = '0; ramload = 32'h0; ramstate = RS_BUSY;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    tick(); tick();
    checks++; if (dwait !== 2'b11 || iwait !== 2'b11) begin errors++; $display("FAIL reset_waits dwait=%b iwait=%b exp 11/11", dwait, iwait); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ram ren=%b wen=%b addr=%h exp 0/0/0", ramREN, ramWEN, ramaddr); end
    checks++; if (ccwait !== 2'b00 || ccinv !== 2'b00 || ccsnoopaddr !== '0) begin errors++; $display("FAIL reset_cc ccwait=%b ccinv=%b exp 00/00", ccwait, ccinv); end
    RST = 1'b0;
    #1;
  endtask

  task automatic test_read_snoop();
    int low_cnt;
    do_reset();
    daddr[0] = 32'h100; dREN = 2'b01; ccwrite = 2'b00; ramstate = RS_BUSY;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rd_idle_ren got=%b exp 0", ramREN); end
    tick(); // SNOOP
    checks++; if (ccwait !== 2'b10 || ccsnoopaddr[1] !== 32'h100 || ccinv !== 2'b00) begin errors++; $display("FAIL rd_snoop ccwait=%b addr=%h ccinv=%b exp 10/100/00", ccwait, ccsnoopaddr[1], ccinv); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL rd_snoop_ram ren=%b wen=%b exp 0/0", ramREN, ramWEN); end
    low_cnt = 0;
    tick(); // DREAD1, BUSY
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 2'b11 || ccwait !== 2'b00) begin errors++; $display("FAIL rd_busy1 ren=%b addr=%h dwait=%b ccwait=%b exp 1/100/11/00", ramREN, ramaddr, dwait, ccwait); end
    tick(); // still DREAD1, BUSY
    checks++; if (ramREN !== 1'b1 || dwait !== 2'b11) begin errors++; $display("FAIL rd_busy2 ren=%b dwait=%b exp 1/11", ramREN, dwait); end
    ramstate = RS_ACCESS; ramload = 32'h1111_0000;
    #1;
    if (dwait[0] === 1'b0) low_cnt++;
    checks++; if (dwait !== 2'b10 || dload[0] !== 32'h1111_0000 || dload[1] !== 32'h0) begin errors++; $display("FAIL rd_word1 dwait=%b dload0=%h exp 10/11110000", dwait, dload[0]); end
    tick(); // DREAD2
    daddr[0] = 32'h104; ramload = 32'h2222_0000;
    #1;
    if (dwait[0] === 1'b0) low_cnt++;
    checks++; if (ramaddr !== 32'h104 || dload[0] !== 32'h2222_0000 || ramREN !== 1'b1) begin errors++; $display("FAIL rd_word2 addr=%h dload0=%h ren=%b exp 104/22220000/1", ramaddr, dload[0], ramREN); end
    tick(); // IDLE
    dREN = 2'b00; ramstate = RS_BUSY;
    #1;
    if (dwait[0] === 1'b0) low_cnt++;
    checks++; if (low_cnt !== 2) begin errors++; $display("FAIL rd_low_cycles got=%0d exp 2", low_cnt); end
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL rd_done ren=%b dwait=%b exp 0/11", ramREN, dwait); end
    // dptr now points at core1: a tie must go to core1
    dREN = 2'b11; daddr[1] = 32'h180;
    tick();
    checks++; if (ccwait !== 2'b01 || ccsnoopaddr[0] !== 32'h180) begin errors++; $display("FAIL rd_dptr ccwait=%b addr=%h exp 01/180", ccwait, ccsnoopaddr[0]); end
  endtask

  task automatic test_snoop_wb();
    do_reset();
    dREN = 2'b10; ccwrite = 2'b11; daddr[1] = 32'h300; daddr[0] = 32'h300;
    dstore[0] = 32'h0000_DEAD; ramstate = RS_ACCESS; ramload = 32'hA;
    tick(); // SNOOP
    checks++; if (ccwait !== 2'b01 || ccinv !== 2'b01 || ccsnoopaddr[0] !== 32'h300) begin errors++; $display("FAIL wb_snoop ccwait=%b ccinv=%b addr=%h exp 01/01/300", ccwait, ccinv, ccsnoopaddr[0]); end
    tick(); // SWB1
    ccwrite = 2'b00;
    #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || ramstore !== 32'h0000_DEAD) begin errors++; $display("FAIL wb_swb1 wen=%b ren=%b addr=%h store=%h exp 1/0/300/dead", ramWEN, ramREN, ramaddr, ramstore); end
    checks++; if (ccwait !== 2'b01 || ccinv !== 2'b01 || dwait !== 2'b11) begin errors++; $display("FAIL wb_swb1_cc ccwait=%b ccinv=%b dwait=%b exp 01/01/11", ccwait, ccinv, dwait); end
    tick(); // SWB2
    daddr[0] = 32'h304; dstore[0] = 32'h0000_BEEF;
    #1;
    checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h304 || ramstore !== 32'h0000_BEEF || ccinv !== 2'b01) begin errors++; $display("FAIL wb_swb2 wen=%b addr=%h store=%h ccinv=%b exp 1/304/beef/01", ramWEN, ramaddr, ramstore, ccinv); end
    tick(); // DREAD1 for core1
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h300 || dwait !== 2'b01 || dload[1] !== 32'hA) begin errors++; $display("FAIL wb_read1 ren=%b wen=%b addr=%h dwait=%b dload1=%h exp 1/0/300/01/a", ramREN, ramWEN, ramaddr, dwait, dload[1]); end
    checks++; if (ccwait !== 2'b00 || ccinv !== 2'b00) begin errors++; $display("FAIL wb_read1_cc ccwait=%b ccinv=%b exp 00/00", ccwait, ccinv); end
    tick(); // DREAD2
    checks++; if (ramREN !== 1'b1 || dwait !== 2'b01) begin errors++; $display("FAIL wb_read2 ren=%b dwait=%b exp 1/01", ramREN, dwait); end
    tick(); // IDLE
    dREN = 2'b00;
    #1;
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL wb_done ren=%b dwait=%b exp 0/11", ramREN, dwait); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dREN = 2'b11; iREN = 2'b11; ramstate = RS_ACCESS;
    daddr[0] = 32'h10; daddr[1] = 32'h20; iaddr[0] = 32'h40; iaddr[1] = 32'h50; ramload = 32'h77;
    tick();
    checks++; if (ccwait !== 2'b10) begin errors++; $display("FAIL b2b_first ccwait=%b exp 10", ccwait); end
    tick();
    checks++; if (ramaddr !== 32'h10 || dwait !== 2'b10) begin errors++; $display("FAIL b2b_d0 addr=%h dwait=%b exp 10/10", ramaddr, dwait); end
    tick(); tick(); // IDLE
    dREN = 2'b10;
    tick();
    checks++; if (ccwait !== 2'b01) begin errors++; $display("FAIL b2b_second ccwait=%b exp 01", ccwait); end
    tick();
    checks++; if (ramaddr !== 32'h20 || dwait !== 2'b01) begin errors++; $display("FAIL b2b_d1 addr=%h dwait=%b exp 20/01", ramaddr, dwait); end
    tick(); tick(); // IDLE
    dREN = 2'b00;
    tick(); // IFETCH core0
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 2'b10 || iload[0] !== 32'h77 || dwait !== 2'b11) begin errors++; $display("FAIL b2b_i0 ren=%b addr=%h iwait=%b iload0=%h exp 1/40/10/77", ramREN, ramaddr, iwait, iload[0]); end
    tick(); // IDLE
    iREN = 2'b10;
    tick(); // IFETCH core1
    checks++; if (ramaddr !== 32'h50 || iwait !== 2'b01 || iload[1] !== 32'h77 || iload[0] !== 32'h0) begin errors++; $display("FAIL b2b_i1 addr=%h iwait=%b iload1=%h exp 50/01/77", ramaddr, iwait, iload[1]); end
    tick();
    iREN = 2'b00;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("FAIL b2b_done ren=%b iwait=%b exp 0/11", ramREN, iwait); end
  endtask

  task automatic test_write();
    int ren_seen;
    do_reset();
    ren_seen = 0;
    dWEN = 2'b01; daddr[0] = 32'h200; dstore[0] = 32'h55; ramstate = RS_BUSY;
    tick(); // DWB1
    if (ramREN === 1'b1) ren_seen++;
    checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h200 || ramstore !== 32'h55 || dwait !== 2'b11) begin errors++; $display("FAIL wr_busy wen=%b addr=%h store=%h dwait=%b exp 1/200/55/11", ramWEN, ramaddr, ramstore, dwait); end
    ramstate = RS_ACCESS;
    #1;
    if (ramREN === 1'b1) ren_seen++;
    checks++; if (dwait !== 2'b10) begin errors++; $display("FAIL wr_w1 dwait=%b exp 10", dwait); end
    tick(); // DWB2, request dropped mid-transaction
    daddr[0] = 32'h204; dstore[0] = 32'h66; dWEN = 2'b00;
    #1;
    if (ramREN === 1'b1) ren_seen++;
    checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h204 || ramstore !== 32'h66 || dwait !== 2'b10) begin errors++; $display("FAIL wr_w2 wen=%b addr=%h store=%h dwait=%b exp 1/204/66/10", ramWEN, ramaddr, ramstore, dwait); end
    tick(); // IDLE
    if (ramREN === 1'b1) ren_seen++;
    checks++; if (ramWEN !== 1'b0 || dwait !== 2'b11 || ren_seen !== 0) begin errors++; $display("FAIL wr_done wen=%b dwait=%b ren_seen=%0d exp 0/11/0", ramWEN, dwait, ren_seen); end
    // dptr untouched by a write: tie still goes to core0
    dREN = 2'b11;
    tick();
    checks++; if (ccwait !== 2'b10) begin errors++; $display("FAIL wr_dptr ccwait=%b exp 10", ccwait); end
  endtask

  task automatic test_error_and_reset();
    do_reset();
    dREN = 2'b01; ccwrite = 2'b10; daddr[0] = 32'h400; daddr[1] = 32'h480; dstore[1] = 32'h99;
    ramstate = RS_ERROR;
    tick(); // SNOOP
    checks++; if (ccwait !== 2'b10 || ccinv !== 2'b00) begin errors++; $display("FAIL er_snoop ccwait=%b ccinv=%b exp 10/00", ccwait, ccinv); end
    for (int k = 0; k < 5; k++) begin
      tick(); // SWB1 held by ERROR
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h480 || ccwait !== 2'b10) begin errors++; $display("FAIL er_hold%0d wen=%b ren=%b addr=%h ccwait=%b exp 1/0/480/10", k, ramWEN, ramREN, ramaddr, ccwait); end
    end
    ramstate = RS_ACCESS;
    tick(); // SWB2 only if ERROR truly held in SWB1
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ccwait !== 2'b10) begin errors++; $display("FAIL er_swb2 wen=%b ren=%b ccwait=%b exp 1/0/10", ramWEN, ramREN, ccwait); end
    RST = 1'b1;
    tick();
    RST = 1'b0; dREN = 2'b00; ccwrite = 2'b00;
    #1;
    checks++; if (ccwait !== 2'b00 || dwait !== 2'b11 || iwait !== 2'b11 || ramWEN !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL er_reset ccwait=%b dwait=%b iwait=%b wen=%b ren=%b exp 00/11/11/0/0", ccwait, dwait, iwait, ramWEN, ramREN); end
    tick();
    checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL er_idle wen=%b ren=%b addr=%h exp 0/0/0", ramWEN, ramREN, ramaddr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_read_snoop();
    test_snoop_wb();
    test_back_to_back();
    test_write();
    test_error_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
